alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller for the 8-bit board ALU datapath.
- Turns debounced push-button levels and switch values into operand loads and operation commands.
- Issues one start/valid transaction per operation to the ALU.
- Owns the display registers: 9-bit result/operand bus and 4-bit letter code. Sits between the debouncers and the ALU/seven-segment logic.

Parameters:
- TIMEOUT_CYC, 15, max cycles after alu_start without alu_valid before ERR.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- sw  in  8  switch value: operand on load, opcode on execute
- pb_a  in  1  debounced level, load A
- pb_b  in  1  debounced level, load B
- pb_x  in  1  debounced level, execute
- alu_a  out  8  operand A to ALU
- alu_b  out  8  operand B to ALU
- alu_op  out  3  opcode: 1 add, 2 sub, 3 not A, 4 and, 5 or, 6 xor
- alu_start  out  1  one-cycle command pulse
- alu_result  in  9  {carry/borrow, result} from ALU
- alu_valid  in  1  one-cycle result strobe
- bi  out  9  display bus
- letter  out  4  display letter: A=4'hA, B=4'hB, C=4'hC (result), E=4'hE (error), 0 idle
- busy  out  1  high in EXEC
- done  out  1  one-cycle pulse on result capture
- err  out  1  high in ERR
- op_cnt  out  CNT_W  completed operations, wraps

Behaviour:
- Reset values: all outputs 0, alu_a/alu_b 0, a_vld=b_vld=0, state IDLE, timer 0. Reset overrides everything, including mid-EXEC.
- A late alu_valid after reset is ignored. alu_valid is ignored in any state except EXEC.
- Edge detect: each pb is registered every cycle. A press is a clock edge where pb=1 and the previous sample=0. Held buttons give a single press.
- Priority on simultaneous presses: pb_a > pb_b > pb_x. Lower-priority presses in that cycle are discarded.
- States: IDLE, SHOW, ERR, EXEC. All presses are ignored in EXEC.
- Load A press (any state but EXEC), effective at that edge:
  - alu_a<=sw, a_vld<=1, bi<={0,sw}, letter<=A, err<=0, next SHOW.
- Load B press: same as load A, using alu_b/b_vld and letter B.
- Execute press (any state but EXEC):
  - If !a_vld or !b_vld, or sw[7:3]!=0, or sw[2:0] not in 1..6: next ERR, bi<=0, letter<=E, err<=1. No alu_start.
  - Otherwise: alu_op<=sw[2:0], alu_start<=1 for exactly one cycle, busy<=1, timer<=0, next EXEC.
- EXEC:
  - alu_a, alu_b and alu_op are held stable.
  - timer increments each cycle.
  - alu_valid (accepted from the cycle after alu_start) captures: bi<=alu_result, letter<=C, done pulses 1 cycle, op_cnt+=1 (wraps), busy<=0, next SHOW.
  - If timer reaches TIMEOUT_CYC with no alu_valid: next ERR, letter E, bi 0, busy 0, op_cnt unchanged.
  - If alu_valid and the timeout land in the same cycle, alu_valid wins.
- Result width: the controller does not reinterpret alu_result. Bit 8 is carry for add, borrow for sub, and 0 for logic ops.
- ERR is left only by a press or rst. a_vld and b_vld survive ERR.

Test Plan:
1. rst, pb_a with sw=8'h0F, pb_b with sw=8'h01 -> letter A then B; bi=9'h00F then 9'h001; alu_a=8'h0F, alu_b=8'h01.
2. A=8'hFF, B=8'h01, execute sw=1; model returns 9'h100 after 3 cycles -> alu_start single pulse, busy 4 cycles, bi=9'h100, letter C, done 1 pulse, op_cnt=1.
3. Execute after reset with no loads, then execute with A,B loaded and sw=8'h07, then sw=8'h11 -> err=1, letter E, bi=0 each time; alu_start never asserted.
4. A and B loaded, execute sw=4; ALU never responds -> ERR exactly TIMEOUT_CYC cycles after alu_start; pb_a press then clears err.
5. pb_a and pb_x rise on the same edge with sw=8'h05 -> A loads 8'h05, no alu_start. Holding pb_b 20 cycles produces a single load. Presses during EXEC are ignored.
6. rst asserted mid-EXEC, then alu_valid arrives -> all outputs 0, state IDLE, alu_valid ignored, op_cnt stays 0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 8-bit board ALU: turns debounced button presses and
// switch values into operand loads, one start/valid ALU transaction, and display state.
module alu_seq_ctrl #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sw,
    input  logic             pb_a,
    input  logic             pb_b,
    input  logic             pb_x,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_start,
    input  logic [8:0]       alu_result,
    input  logic             alu_valid,
    output logic [8:0]       bi,
    output logic [3:0]       letter,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] LET_A = 4'hA;
    localparam logic [3:0] LET_B = 4'hB;
    localparam logic [3:0] LET_C = 4'hC;
    localparam logic [3:0] LET_E = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ERR  = 2'd2,
        EXEC = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               pb_a_q_r, pb_b_q_r, pb_x_q_r;
    logic               press_a_s, press_b_s, press_x_s, exec_ok_s;
    logic               a_vld_r, b_vld_r, a_vld_s, b_vld_s;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [7:0]         alu_a_s, alu_b_s;
    logic [2:0]         alu_op_s;
    logic               alu_start_s, busy_s, done_s, err_s;
    logic [8:0]         bi_s;
    logic [3:0]         letter_s;
    logic [CNT_W-1:0]   op_cnt_s;

    // Only opcodes 1..6 with the upper switch bits clear are executable.
    function automatic logic op_legal(input logic [7:0] v);
        return (v[7:3] == 5'd0) && (v[2:0] >= 3'd1) && (v[2:0] <= 3'd6);
    endfunction

    assign press_a_s = pb_a & ~pb_a_q_r;
    assign press_b_s = pb_b & ~pb_b_q_r;
    assign press_x_s = pb_x & ~pb_x_q_r;
    assign exec_ok_s = a_vld_r & b_vld_r & op_legal(sw);

    // Next-state and next-output logic; priority A > B > X, presses ignored in EXEC.
    always_comb begin
        state_s     = state_r;
        a_vld_s     = a_vld_r;
        b_vld_s     = b_vld_r;
        timer_s     = timer_r;
        alu_a_s     = alu_a;
        alu_b_s     = alu_b;
        alu_op_s    = alu_op;
        alu_start_s = 1'b0;
        bi_s        = bi;
        letter_s    = letter;
        busy_s      = busy;
        done_s      = 1'b0;
        err_s       = err;
        op_cnt_s    = op_cnt;
        case (state_r)
            EXEC: begin
                // A strobe coincident with the start pulse belongs to no transaction.
                if (alu_valid && !alu_start) begin
                    bi_s     = alu_result;
                    letter_s = LET_C;
                    done_s   = 1'b1;
                    op_cnt_s = op_cnt + CNT_W'(1);
                    busy_s   = 1'b0;
                    state_s  = SHOW;
                end else if (timer_r == TMR_LAST) begin
                    bi_s     = 9'd0;
                    letter_s = LET_E;
                    err_s    = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = ERR;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            IDLE, SHOW, ERR: begin
                if (press_a_s) begin
                    alu_a_s  = sw;
                    a_vld_s  = 1'b1;
                    bi_s     = {1'b0, sw};
                    letter_s = LET_A;
                    err_s    = 1'b0;
                    state_s  = SHOW;
                end else if (press_b_s) begin
                    alu_b_s  = sw;
                    b_vld_s  = 1'b1;
                    bi_s     = {1'b0, sw};
                    letter_s = LET_B;
                    err_s    = 1'b0;
                    state_s  = SHOW;
                end else if (press_x_s) begin
                    if (exec_ok_s) begin
                        alu_op_s    = sw[2:0];
                        alu_start_s = 1'b1;
                        busy_s      = 1'b1;
                        err_s       = 1'b0;
                        timer_s     = {TMR_W{1'b0}};
                        state_s     = EXEC;
                    end else begin
                        bi_s     = 9'd0;
                        letter_s = LET_E;
                        err_s    = 1'b1;
                        state_s  = ERR;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, button history and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pb_a_q_r  <= 1'b0;
            pb_b_q_r  <= 1'b0;
            pb_x_q_r  <= 1'b0;
            a_vld_r   <= 1'b0;
            b_vld_r   <= 1'b0;
            timer_r   <= {TMR_W{1'b0}};
            alu_a     <= 8'd0;
            alu_b     <= 8'd0;
            alu_op    <= 3'd0;
            alu_start <= 1'b0;
            bi        <= 9'd0;
            letter    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            op_cnt    <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pb_a_q_r  <= pb_a;
            pb_b_q_r  <= pb_b;
            pb_x_q_r  <= pb_x;
            a_vld_r   <= a_vld_s;
            b_vld_r   <= b_vld_s;
            timer_r   <= timer_s;
            alu_a     <= alu_a_s;
            alu_b     <= alu_b_s;
            alu_op    <= alu_op_s;
            alu_start <= alu_start_s;
            bi        <= bi_s;
            letter    <= letter_s;
            busy      <= busy_s;
            done      <= done_s;
            err       <= err_s;
            op_cnt    <= op_cnt_s;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a vector table, hand-written corner sequences
// and randomized operations checked against a transaction-level model.
module tb_alu_seq_ctrl;

    localparam int TO = 15;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    sw = 8'd0;
    logic          pb_a = 1'b0, pb_b = 1'b0, pb_x = 1'b0;
    logic [8:0]    alu_result = 9'd0;
    logic          alu_valid = 1'b0;
    logic [7:0]    alu_a, alu_b;
    logic [2:0]    alu_op;
    logic          alu_start, busy, done, err;
    logic [8:0]    bi;
    logic [3:0]    letter;
    logic [CW-1:0] op_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // transaction-level model state
    logic [7:0]    ma, mb;
    bit            mav, mbv, merr;
    logic [8:0]    mbi;
    logic [3:0]    ml;
    logic [CW-1:0] mcnt;

    typedef struct {
        int         kind;   // 0 load A, 1 load B, 2 execute
        logic [7:0] swv;
        int         lat;    // ALU response latency in cycles after start
        bit         start;
        logic [3:0] letter;
        logic [8:0] bi;
        bit         err;
        logic [7:0] cnt;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    vec_t vt[14];

    alu_seq_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sw(sw), .pb_a(pb_a), .pb_b(pb_b), .pb_x(pb_x),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_valid(alu_valid), .bi(bi), .letter(letter),
        .busy(busy), .done(done), .err(err), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd1: return {1'b0, a} + {1'b0, b};
            3'd2: return {1'b0, a} - {1'b0, b};
            3'd3: return {1'b0, ~a};
            3'd4: return {1'b0, a & b};
            3'd5: return {1'b0, a | b};
            3'd6: return {1'b0, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] l, input logic [8:0] b9,
                               input bit e, input logic [CW-1:0] c, input logic [7:0] a, input logic [7:0] b);
        check({tag, ".letter"}, 32'(letter), 32'(l));
        check({tag, ".bi"}, 32'(bi), 32'(b9));
        check({tag, ".err"}, 32'(err), 32'(e));
        check({tag, ".op_cnt"}, 32'(op_cnt), 32'(c));
        check({tag, ".alu_a"}, 32'(alu_a), 32'(a));
        check({tag, ".alu_b"}, 32'(alu_b), 32'(b));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".alu_start"}, 32'(alu_start), 32'd0);
    endtask

    task automatic check_model(input string tag);
        check_state(tag, ml, mbi, merr, mcnt, ma, mb);
    endtask

    // Apply the spec rules for one press; ALU answers lat cycles after the start pulse.
    task automatic model_op(input int kind, input logic [7:0] swv, input int lat, output bit exp_start);
        exp_start = 1'b0;
        if (kind == 0) begin
            ma = swv; mav = 1'b1; mbi = {1'b0, swv}; ml = 4'hA; merr = 1'b0;
        end else if (kind == 1) begin
            mb = swv; mbv = 1'b1; mbi = {1'b0, swv}; ml = 4'hB; merr = 1'b0;
        end else if (!(mav && mbv) || swv[7:3] != 5'd0 || swv[2:0] == 3'd0 || swv[2:0] == 3'd7) begin
            merr = 1'b1; mbi = 9'd0; ml = 4'hE;
        end else begin
            exp_start = 1'b1;
            if (lat >= 1 && lat <= TO - 1) begin
                mbi = ref_alu(ma, mb, swv[2:0]); ml = 4'hC; merr = 1'b0; mcnt = mcnt + 1'b1;
            end else begin
                mbi = 9'd0; ml = 4'hE; merr = 1'b1;
            end
        end
    endtask

    // Press one button for a cycle; for execute, act as the ALU and check the handshake timing.
    task automatic do_op(input int kind, input logic [7:0] swv, input int lat, input bit exp_start, input int press_at);
        int start_n, busy_n, done_n, err_at;
        bit captured, stable;
        logic [7:0] a0, b0;
        logic [2:0] op0;
        sw = swv;
        if (kind == 0) pb_a = 1'b1;
        else if (kind == 1) pb_b = 1'b1;
        else pb_x = 1'b1;
        step();
        pb_a = 1'b0; pb_b = 1'b0; pb_x = 1'b0;
        if (kind == 2) begin
            start_n = int'(alu_start); busy_n = int'(busy); done_n = 0; err_at = -1;
            a0 = alu_a; b0 = alu_b; op0 = alu_op; stable = 1'b1;
            check("start_first", 32'(alu_start), 32'(exp_start));
            if (exp_start) check("alu_op", 32'(alu_op), 32'(swv[2:0]));
            for (int i = 1; i <= TO + 4; i++) begin
                alu_valid  = (start_n > 0) && (i == lat + 1);
                alu_result = ref_alu(alu_a, alu_b, alu_op);
                if (i == press_at) begin
                    pb_a = 1'b1; pb_b = 1'b1; pb_x = 1'b1; sw = 8'hAA;
                end else if (i == press_at + 1) begin
                    pb_a = 1'b0; pb_b = 1'b0; pb_x = 1'b0; sw = swv;
                end
                step();
                alu_valid = 1'b0;
                start_n += int'(alu_start);
                busy_n  += int'(busy);
                done_n  += int'(done);
                if (err && err_at < 0) err_at = i;
                if (busy && (alu_a !== a0 || alu_b !== b0 || alu_op !== op0)) stable = 1'b0;
            end
            captured = exp_start && lat >= 1 && lat <= TO - 1;
            check("start_count", 32'(start_n), exp_start ? 32'd1 : 32'd0);
            check("done_count", 32'(done_n), captured ? 32'd1 : 32'd0);
            check("busy_cycles", 32'(busy_n), !exp_start ? 32'd0 : (captured ? 32'(lat + 1) : 32'(TO)));
            if (exp_start) check("err_at", 32'(err_at), captured ? 32'hFFFF_FFFF : 32'(TO));
            if (exp_start) check("exec_stable", 32'(stable), 32'd1);
        end
        // stray strobe outside EXEC must be ignored
        alu_valid  = 1'b1;
        alu_result = 9'($urandom);
        step();
        alu_valid = 1'b0;
    endtask

    initial begin
        bit es;
        int kind, lat;
        logic [7:0] swv;

        vt[0]  = '{2, 8'h01, 1,  1'b0, 4'hE, 9'h000, 1'b1, 8'd0, 8'h00, 8'h00};
        vt[1]  = '{0, 8'h0F, 0,  1'b0, 4'hA, 9'h00F, 1'b0, 8'd0, 8'h0F, 8'h00};
        vt[2]  = '{1, 8'h01, 0,  1'b0, 4'hB, 9'h001, 1'b0, 8'd0, 8'h0F, 8'h01};
        vt[3]  = '{2, 8'h07, 1,  1'b0, 4'hE, 9'h000, 1'b1, 8'd0, 8'h0F, 8'h01};
        vt[4]  = '{2, 8'h11, 1,  1'b0, 4'hE, 9'h000, 1'b1, 8'd0, 8'h0F, 8'h01};
        vt[5]  = '{0, 8'hFF, 0,  1'b0, 4'hA, 9'h0FF, 1'b0, 8'd0, 8'hFF, 8'h01};
        vt[6]  = '{2, 8'h01, 3,  1'b1, 4'hC, 9'h100, 1'b0, 8'd1, 8'hFF, 8'h01};
        vt[7]  = '{2, 8'h02, 5,  1'b1, 4'hC, 9'h0FE, 1'b0, 8'd2, 8'hFF, 8'h01};
        vt[8]  = '{2, 8'h04, 99, 1'b1, 4'hE, 9'h000, 1'b1, 8'd2, 8'hFF, 8'h01};
        vt[9]  = '{0, 8'h05, 0,  1'b0, 4'hA, 9'h005, 1'b0, 8'd2, 8'h05, 8'h01};
        vt[10] = '{2, 8'h06, 14, 1'b1, 4'hC, 9'h004, 1'b0, 8'd3, 8'h05, 8'h01};
        vt[11] = '{2, 8'h03, 15, 1'b1, 4'hE, 9'h000, 1'b1, 8'd3, 8'h05, 8'h01};
        vt[12] = '{1, 8'h80, 0,  1'b0, 4'hB, 9'h080, 1'b0, 8'd3, 8'h05, 8'h80};
        vt[13] = '{2, 8'h01, 1,  1'b1, 4'hC, 9'h085, 1'b0, 8'd4, 8'h05, 8'h80};

        // reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_state("reset", 4'h0, 9'h000, 1'b0, '0, 8'h00, 8'h00);
        check("reset.alu_op", 32'(alu_op), 32'd0);

        foreach (vt[k]) begin
            do_op(vt[k].kind, vt[k].swv, vt[k].lat, vt[k].start, -1);
            check_state($sformatf("vec%0d", k), vt[k].letter, vt[k].bi, vt[k].err, CW'(vt[k].cnt), vt[k].a, vt[k].b);
        end

        ma = 8'h05; mb = 8'h80; mav = 1'b1; mbv = 1'b1; mbi = 9'h085; ml = 4'hC; merr = 1'b0; mcnt = CW'(4);

        // simultaneous load A and execute: A wins, execute discarded
        sw = 8'h05; pb_a = 1'b1; pb_x = 1'b1;
        step();
        check("simul.alu_start", 32'(alu_start), 32'd0);
        check("simul.letter", 32'(letter), 32'hA);
        pb_a = 1'b0; pb_x = 1'b0;
        step();
        check("simul.alu_start2", 32'(alu_start), 32'd0);
        ma = 8'h05; mbi = 9'h005; ml = 4'hA;
        check_model("simul");

        // held B button loads once
        sw = 8'h33; pb_b = 1'b1;
        step();
        sw = 8'h44;
        for (int i = 0; i < 19; i++) step();
        pb_b = 1'b0;
        step();
        mb = 8'h33; mbi = 9'h033; ml = 4'hB;
        check_model("hold_b");

        // presses during EXEC are ignored
        model_op(2, 8'h01, 6, es);
        do_op(2, 8'h01, 6, es, 2);
        check_model("exec_press");

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom % 3);
            lat  = int'($urandom_range(1, TO + 2));
            if (kind == 2 && ($urandom % 4) != 0) swv = {5'd0, 3'($urandom_range(1, 6))};
            else swv = 8'($urandom);
            model_op(kind, swv, lat, es);
            do_op(kind, swv, lat, es, -1);
            check_model($sformatf("rand%0d", n));
        end

        // counter wrap
        for (int n = 0; n < 256; n++) begin
            model_op(2, 8'h06, 1, es);
            do_op(2, 8'h06, 1, es, -1);
        end
        check_model("wrap");

        // reset in the middle of EXEC, then a late strobe
        model_op(0, 8'h10, 0, es); do_op(0, 8'h10, 0, es, -1);
        model_op(1, 8'h20, 0, es); do_op(1, 8'h20, 0, es, -1);
        sw = 8'h01; pb_x = 1'b1;
        step();
        pb_x = 1'b0;
        check("midrst.busy", 32'(busy), 32'd1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ma = 8'h00; mb = 8'h00; mav = 1'b0; mbv = 1'b0; mbi = 9'h000; ml = 4'h0; merr = 1'b0; mcnt = '0;
        check_model("midrst");
        alu_valid = 1'b1; alu_result = 9'h1AB;
        step();
        alu_valid = 1'b0;
        step();
        check_model("late_valid");
        check("late_valid.alu_op", 32'(alu_op), 32'd0);
        model_op(2, 8'h01, 1, es);
        do_op(2, 8'h01, 1, es, -1);
        check_model("post_rst_exec");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
